regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register and port.
REQ-002 SHALL have parameter AW, default 4, address width; 2**AW architectural indices; index 2**AW-1 is PC, not stored.
REQ-003 SHALL have parameter BYPASS, default 1; 1 = same-cycle write data forwarded to reads, 0 = reads return stored value.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 ra1, ra2  input  AW  read addresses.
REQ-007 rd1, rd2  output  WIDTH  combinational read data.
REQ-008 rd1_busy, rd2_busy  output  1  scoreboard busy bit of ra1/ra2; 0 when the address is PC.
REQ-009 r15  input  WIDTH  PC+8 value returned for reads of index 2**AW-1.
REQ-010 we3, wa3, wd3  input  1/AW/WIDTH  write port A (ALU/load result).
REQ-011 we4, wa4, wd4  input  1/AW/WIDTH  write port B (long-latency result, e.g. multiply high word); clears busy of wa4.
REQ-012 claim, claim_addr  input  1/AW  marks a register busy at issue of a long-latency op.
REQ-013 busy_vec  output  2**AW  registered busy bits; bit 2**AW-1 always 0.
REQ-014 wr_conflict  output  1  sticky flag: both ports wrote the same address in one cycle.

Function
REQ-015 Storage SHALL be 2**AW-1 registers of WIDTH bits, written on rising clk only.
REQ-016 we3=1 and wa3 != PC index SHALL write wd3 to rf[wa3] at the edge.
REQ-017 we4=1 and wa4 != PC index SHALL write wd4 to rf[wa4] and clear busy[wa4] at the edge.
REQ-018 Writes to the PC index on either port SHALL be ignored; no storage or busy change.
REQ-019 we3=we4=1 with wa3==wa4 (non-PC): port B data SHALL win; wr_conflict SHALL set the next cycle and hold until reset.
REQ-020 claim=1 with claim_addr != PC index SHALL set busy[claim_addr] at the edge; a PC-index claim is ignored.
REQ-021 claim and port B clear of the same address in one cycle: claim SHALL win, busy stays 1.
REQ-022 Port A write to a busy register SHALL write data and leave busy unchanged.
REQ-023 Claim of an already-busy register SHALL keep busy=1 with no error.
REQ-024 Read of PC index SHALL return r15 regardless of BYPASS or writes.
REQ-025 BYPASS=1: rdN SHALL return wd4 if we4 and wa4==raN, else wd3 if we3 and wa3==raN, else rf[raN].
REQ-026 BYPASS=1: rdN_busy SHALL be 0 when port B writes raN that cycle and no same-cycle claim targets raN.
REQ-027 BYPASS=0: rdN and rdN_busy SHALL reflect registered state only; writes visible the cycle after the edge.
REQ-028 All read outputs SHALL be combinational with zero-cycle latency; write latency 1 edge.

Reset
REQ-029 reset=1 SHALL asynchronously clear all stored registers to 0, all busy bits to 0 and wr_conflict to 0.
REQ-030 While reset=1, writes and claims SHALL be ignored; rd1/rd2 return 0 except PC-index reads return r15.
REQ-031 Reset asserted mid-operation (register busy, write pending) SHALL leave no busy bit set and no partial write after deassertion.

Verification
REQ-032 Reset, then read all indices 0..14 -> rd=0, busy=0; ra1=15 with r15=0x100 -> rd1=0x100.
REQ-033 we3, wa3=2, wd3=0xA5A5A5A5; same cycle ra1=2 -> rd1=0xA5A5A5A5 (BYPASS=1) or old 0 (BYPASS=0); next cycle 0xA5A5A5A5 both.
REQ-034 claim r5; next cycle rd1_busy=1, busy_vec[5]=1; we4 wa4=5 wd4=0x1234 -> following cycle busy_vec[5]=0, rd=0x1234.
REQ-035 we3 wa3=7 wd3=0x11 and we4 wa4=7 wd4=0x22 same edge -> rf[7]=0x22, wr_conflict=1 and sticky until reset.
REQ-036 claim r3 and we4 wa4=3 same edge -> busy_vec[3]=1, rf[3]=wd4; we3 wa3=15 -> no storage change.
REQ-037 Set busy r1, r9; assert reset between edges -> busy_vec=0, rf all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with a scoreboard of busy bits.
// The top architectural index is the program counter. It is never stored:
// reads of it return the r15 input (PC+8), and writes or claims to it are
// dropped. Port A carries ALU/load results. Port B carries long-latency
// results and also retires the scoreboard entry of its target. A claim marks
// a register busy when a long-latency op issues. Reads are combinational and
// can optionally forward same-cycle write data.

module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int AW     = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,

  // read ports
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              rd1_busy,
  output logic              rd2_busy,
  input  logic [WIDTH-1:0]  r15,

  // write port A (ALU / load)
  input  logic              we3,
  input  logic [AW-1:0]     wa3,
  input  logic [WIDTH-1:0]  wd3,

  // write port B (long-latency result, retires the busy bit)
  input  logic              we4,
  input  logic [AW-1:0]     wa4,
  input  logic [WIDTH-1:0]  wd4,

  // scoreboard claim at issue
  input  logic              claim,
  input  logic [AW-1:0]     claim_addr,

  output logic [2**AW-1:0]  busy_vec,
  output logic              wr_conflict
);

  localparam int          NREG   = 2 ** AW;
  localparam int          NSTORE = NREG - 1;
  localparam logic [AW-1:0] PC_IDX = {AW{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  rf [NSTORE];
  logic [NSTORE-1:0] busy_q;
  logic              conflict_q;

  // --------------------------------------------------------------------------
  // Qualified requests: anything aimed at the PC index is dropped here so the
  // per-register logic below never has to think about it.
  // --------------------------------------------------------------------------
  logic wr_a;
  logic wr_b;
  logic claim_ok;
  logic conflict_now;

  assign wr_a         = we3   && (wa3 != PC_IDX);
  assign wr_b         = we4   && (wa4 != PC_IDX);
  assign claim_ok     = claim && (claim_addr != PC_IDX);
  assign conflict_now = wr_a && wr_b && (wa3 == wa4);

  // --------------------------------------------------------------------------
  // Per-register write selects and next busy state
  // --------------------------------------------------------------------------
  logic [NSTORE-1:0] sel_a;
  logic [NSTORE-1:0] sel_b;
  logic [NSTORE-1:0] sel_claim;
  logic [NSTORE-1:0] busy_d;

  // Decode the three request addresses into one-hot per-register selects.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    sel_a     = '0;
    sel_b     = '0;
    sel_claim = '0;
    for (int i = 0; i < NSTORE; i++) begin
      sel_a[i]     = wr_a     && (wa3        == AW'(i));
      sel_b[i]     = wr_b     && (wa4        == AW'(i));
      sel_claim[i] = claim_ok && (claim_addr == AW'(i));
    end
  end

  // Busy update: port B retires an entry, a claim sets one; a claim on the
  // same register in the same cycle wins over the retire. Port A never
  // touches the scoreboard.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NSTORE; i++) begin
      if (sel_b[i])     busy_d[i] = 1'b0;
      if (sel_claim[i]) busy_d[i] = 1'b1;
    end
  end

  // Register storage: port B wins when both ports target the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the array is cleared by reset on purpose so every register reads
      // 0 as soon as reset is asserted; this keeps it in flops, not in a RAM.
      for (int i = 0; i < NSTORE; i++) begin
        // NOTE: state is assigned with <= so every flop samples pre-edge values
        // regardless of statement order.
        rf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSTORE; i++) begin
        if (sel_b[i]) begin
          rf[i] <= wd4;
        end else if (sel_a[i]) begin
          rf[i] <= wd3;
        end
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Sticky record that both ports hit the same register in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_q <= 1'b0;
    end else if (conflict_now) begin
      conflict_q <= 1'b1;
    end
  end

  assign busy_vec    = {1'b0, busy_q};
  assign wr_conflict = conflict_q;

  // --------------------------------------------------------------------------
  // Read ports. Both ports share the same logic, so it is written once over a
  // small array of port indices.
  // --------------------------------------------------------------------------
  logic [AW-1:0]    ra_p   [2];
  logic [WIDTH-1:0] rd_p   [2];
  logic             busy_p [2];

  assign ra_p[0] = ra1;
  assign ra_p[1] = ra2;

  for (genvar p = 0; p < 2; p++) begin : g_read
    // PC reads return r15; reads during reset return 0 with no forwarding;
    // otherwise stored data, optionally overridden by same-cycle writes.
    always_comb begin
      rd_p[p]   = '0;
      busy_p[p] = 1'b0;
      if (ra_p[p] == PC_IDX) begin
        rd_p[p] = r15;
      end else if (!reset) begin
        rd_p[p]   = rf[ra_p[p]];
        busy_p[p] = busy_q[ra_p[p]];
        if (BYPASS) begin
          if (we4 && (wa4 == ra_p[p])) begin
            rd_p[p] = wd4;
          end else if (we3 && (wa3 == ra_p[p])) begin
            rd_p[p] = wd3;
          end
          // A retire this cycle is forwarded unless a claim re-marks it.
          if (we4 && (wa4 == ra_p[p]) && !(claim && (claim_addr == ra_p[p]))) begin
            busy_p[p] = 1'b0;
          end
        end
      end
    end
  end

  assign rd1      = rd_p[0];
  assign rd2      = rd_p[1];
  assign rd1_busy = busy_p[0];
  assign rd2_busy = busy_p[1];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors for regfile_sb. Two instances share all
// inputs: u_dut forwards same-cycle writes, u_nb does not. Each table row is
// driven after a falling edge, compared 1 ns later, then committed by the
// next rising edge.

module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic [3:0]  ra1, ra2;
  logic [31:0] r15;
  logic        we3, we4, claim;
  logic [3:0]  wa3, wa4, claim_addr;
  logic [31:0] wd3, wd4;

  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        rd1_busy, rd2_busy, nb_rd1_busy, nb_rd2_busy;
  logic [15:0] busy_vec, nb_busy_vec;
  logic        wr_conflict, nb_wr_conflict;

  int n_total = 0;
  int n_pass  = 0;

  regfile_sb #(.WIDTH(32), .AW(4), .BYPASS(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .r15(r15),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .claim(claim), .claim_addr(claim_addr),
    .busy_vec(busy_vec), .wr_conflict(wr_conflict)
  );

  regfile_sb #(.WIDTH(32), .AW(4), .BYPASS(1'b0)) u_nb (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
    .rd1_busy(nb_rd1_busy), .rd2_busy(nb_rd2_busy), .r15(r15),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .claim(claim), .claim_addr(claim_addr),
    .busy_vec(nb_busy_vec), .wr_conflict(nb_wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] r15;
    logic        we3;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic        we4;
    logic [3:0]  wa4;
    logic [31:0] wd4;
    logic        claim;
    logic [3:0]  claim_addr;
    logic [31:0] e_rd1;
    logic        e_b1;
    logic [31:0] e_rd2;
    logic        e_b2;
    logic [15:0] e_bv;
    logic        e_wc;
    logic [31:0] e_nb_rd1;
    logic        e_nb_b1;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; wa3 = 4'd0; wd3 = 32'h0;
    we4 = 1'b0; wa4 = 4'd0; wd4 = 32'h0;
    claim = 1'b0; claim_addr = 4'd0;
    ra1 = 4'd0; ra2 = 4'd0; r15 = 32'h0;
  endtask

  initial begin
    //          ra1    ra2    r15           we3   wa3    wd3           we4   wa4    wd4           clm   caddr  e_rd1         b1    e_rd2         b2    e_bv       wc    nb_rd1        nb_b1
    vecs[0]  = '{4'd2, 4'd15, 32'h100,      1'b1, 4'd2,  32'hA5A5A5A5, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'hA5A5A5A5, 1'b0, 32'h100,      1'b0, 16'h0000,  1'b0, 32'h0,        1'b0};
    vecs[1]  = '{4'd2, 4'd3,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 16'h0000,  1'b0, 32'hA5A5A5A5, 1'b0};
    vecs[2]  = '{4'd5, 4'd2,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd5,  32'h0,        1'b0, 32'hA5A5A5A5, 1'b0, 16'h0000,  1'b0, 32'h0,        1'b0};
    vecs[3]  = '{4'd5, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 32'h0,        1'b0, 16'h0020,  1'b0, 32'h0,        1'b1};
    vecs[4]  = '{4'd5, 4'd5,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd5,  32'h1234,     1'b0, 4'd0,  32'h1234,     1'b0, 32'h1234,     1'b0, 16'h0020,  1'b0, 32'h0,        1'b1};
    vecs[5]  = '{4'd5, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h1234,     1'b0, 32'h0,        1'b0, 16'h0000,  1'b0, 32'h1234,     1'b0};
    vecs[6]  = '{4'd7, 4'd7,  32'h0,        1'b1, 4'd7,  32'h11,       1'b1, 4'd7,  32'h22,       1'b0, 4'd0,  32'h22,       1'b0, 32'h22,       1'b0, 16'h0000,  1'b0, 32'h0,        1'b0};
    vecs[7]  = '{4'd7, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h22,       1'b0, 32'h0,        1'b0, 16'h0000,  1'b1, 32'h22,       1'b0};
    vecs[8]  = '{4'd3, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd3,  32'h333,      1'b1, 4'd3,  32'h333,      1'b0, 32'h0,        1'b0, 16'h0000,  1'b1, 32'h0,        1'b0};
    vecs[9]  = '{4'd3, 4'd15, 32'h200,      1'b1, 4'd15, 32'hDEAD,     1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h333,      1'b1, 32'h200,      1'b0, 16'h0008,  1'b1, 32'h333,      1'b1};
    vecs[10] = '{4'd3, 4'd15, 32'h300,      1'b0, 4'd0,  32'h0,        1'b1, 4'd15, 32'hBEEF,     1'b1, 4'd15, 32'h333,      1'b1, 32'h300,      1'b0, 16'h0008,  1'b1, 32'h333,      1'b1};
    vecs[11] = '{4'd3, 4'd0,  32'h0,        1'b1, 4'd3,  32'h44,       1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h44,       1'b1, 32'h0,        1'b0, 16'h0008,  1'b1, 32'h333,      1'b1};
    vecs[12] = '{4'd3, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd3,  32'h44,       1'b1, 32'h0,        1'b0, 16'h0008,  1'b1, 32'h44,       1'b1};
    vecs[13] = '{4'd3, 4'd2,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h44,       1'b1, 32'hA5A5A5A5, 1'b0, 16'h0008,  1'b1, 32'h44,       1'b1};
    vecs[14] = '{4'd0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd1,  32'h0,        1'b0, 32'h0,        1'b0, 16'h0008,  1'b1, 32'h0,        1'b0};
    vecs[15] = '{4'd1, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd9,  32'h0,        1'b1, 32'h0,        1'b0, 16'h000A,  1'b1, 32'h0,        1'b1};
    vecs[16] = '{4'd9, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 32'h0,        1'b0, 16'h020A,  1'b1, 32'h0,        1'b1};

    // Reset state while reset is held.
    idle_inputs();
    reset = 1'b1;
    #12;
    check("reset busy_vec", 32'(busy_vec), 32'h0);
    check("reset wr_conflict", 32'(wr_conflict), 32'h0);

    // Release reset on a falling edge, then read every stored index and PC.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      ra1 = 4'(i);
      ra2 = 4'(14 - i);
      #1;
      check($sformatf("init rd1[%0d]", i), rd1, 32'h0);
      check($sformatf("init busy1[%0d]", i), 32'(rd1_busy), 32'h0);
      check($sformatf("init rd2[%0d]", 14 - i), rd2, 32'h0);
    end
    ra1 = 4'd15;
    r15 = 32'h100;
    #1;
    check("init pc read", rd1, 32'h100);
    check("init pc busy", 32'(rd1_busy), 32'h0);

    // Table-driven sequence.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2; r15 = vecs[i].r15;
      we3 = vecs[i].we3; wa3 = vecs[i].wa3; wd3 = vecs[i].wd3;
      we4 = vecs[i].we4; wa4 = vecs[i].wa4; wd4 = vecs[i].wd4;
      claim = vecs[i].claim; claim_addr = vecs[i].claim_addr;
      #1;
      check($sformatf("v%0d rd1", i), rd1, vecs[i].e_rd1);
      check($sformatf("v%0d rd1_busy", i), 32'(rd1_busy), 32'(vecs[i].e_b1));
      check($sformatf("v%0d rd2", i), rd2, vecs[i].e_rd2);
      check($sformatf("v%0d rd2_busy", i), 32'(rd2_busy), 32'(vecs[i].e_b2));
      check($sformatf("v%0d busy_vec", i), 32'(busy_vec), 32'(vecs[i].e_bv));
      check($sformatf("v%0d wr_conflict", i), 32'(wr_conflict), 32'(vecs[i].e_wc));
      check($sformatf("v%0d nb rd1", i), nb_rd1, vecs[i].e_nb_rd1);
      check($sformatf("v%0d nb rd1_busy", i), 32'(nb_rd1_busy), 32'(vecs[i].e_nb_b1));
    end

    // Asynchronous reset between edges with busy registers and writes pending.
    @(negedge clk);
    we3 = 1'b1; wa3 = 4'd2; wd3 = 32'h55;
    we4 = 1'b1; wa4 = 4'd9; wd4 = 32'h99;
    claim = 1'b1; claim_addr = 4'd4;
    ra1 = 4'd2; ra2 = 4'd15; r15 = 32'h400;
    #2;
    reset = 1'b1;
    #1;
    check("async busy_vec", 32'(busy_vec), 32'h0);
    check("async wr_conflict", 32'(wr_conflict), 32'h0);
    check("async rd1 no fwd", rd1, 32'h0);
    check("async rd2 pc", rd2, 32'h400);
    check("async rd1_busy", 32'(rd1_busy), 32'h0);
    check("async nb rd1", nb_rd1, 32'h0);
    ra1 = 4'd3;
    #1;
    check("async rf3 cleared", rd1, 32'h0);

    // Hold reset across a rising edge with writes active, then release.
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 15; i++) begin
      ra1 = 4'(i);
      #1;
      check($sformatf("post rd1[%0d]", i), rd1, 32'h0);
    end
    check("post busy_vec", 32'(busy_vec), 32'h0);
    check("post wr_conflict", 32'(wr_conflict), 32'h0);

    // Normal operation resumes after reset.
    @(negedge clk);
    we3 = 1'b1; wa3 = 4'd4; wd3 = 32'h66;
    @(negedge clk);
    idle_inputs();
    ra1 = 4'd4;
    #1;
    check("resume write nb", nb_rd1, 32'h66);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
